// File: rtl/fec_encoder_if.sv
// rtl/fec_encoder_if.sv - row input and frame/parity output handshake bundle for fec_encoder
interface fec_encoder_if #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
);
    logic [WIDTH-1:0]       s_data;
    logic                   s_valid;
    logic                   s_last;
    logic                   s_ready;
    logic [DEPTH*WIDTH-1:0] data_out;
    logic [DEPTH-1:0]       row_parity;
    logic [WIDTH-1:0]       col_parity;
    logic                   total_parity;
    logic                   out_valid;
    logic                   out_ready;
    logic                   frame_err;
    logic [15:0]            frame_cnt;

    modport master (
        output s_data, s_valid, s_last, out_ready,
        input  s_ready, data_out, row_parity, col_parity, total_parity,
               out_valid, frame_err, frame_cnt
    );

    modport slave (
        input  s_data, s_valid, s_last, out_ready,
        output s_ready, data_out, row_parity, col_parity, total_parity,
               out_valid, frame_err, frame_cnt
    );
endinterface

// File: rtl/fec_encoder.sv
// rtl/fec_encoder.sv - 2-D even-parity frame encoder: collects DEPTH rows, emits frame plus row/col/total parity
module fec_encoder #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    fec_encoder_if.slave  bus
);
    localparam logic [0:0] FILL = 1'b0;
    localparam logic [0:0] HOLD = 1'b1;
    localparam int         CW   = $clog2(DEPTH);
    localparam logic [CW-1:0] LAST_ROW = CW'(DEPTH - 1);

    logic [0:0]             r_state;
    logic [CW-1:0]          r_row_cnt;
    logic [DEPTH*WIDTH-1:0] r_data;
    logic [DEPTH-1:0]       r_row_par;
    logic [WIDTH-1:0]       r_col_par;
    logic                   r_tot_par;
    logic                   r_frame_err;
    logic [15:0]            r_frame_cnt;

    logic w_accept;
    logic w_at_last_row;
    logic w_close;
    logic w_handoff;

    assign bus.s_ready     = (r_state == FILL) && !rst;
    assign w_accept        = bus.s_valid && bus.s_ready;
    assign w_at_last_row   = (r_row_cnt == LAST_ROW);
    assign w_close         = w_accept && (bus.s_last || w_at_last_row);
    assign w_handoff       = (r_state == HOLD) && bus.out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= FILL;
            r_row_cnt   <= '0;
            r_data      <= '0;
            r_row_par   <= '0;
            r_col_par   <= '0;
            r_tot_par   <= 1'b0;
            r_frame_err <= 1'b0;
            r_frame_cnt <= '0;
        end else begin
            r_frame_err <= 1'b0;
            case (r_state)
                FILL: begin
                    if (w_accept) begin
                        r_data[int'(r_row_cnt)*WIDTH +: WIDTH] <= bus.s_data;
                        r_row_par[r_row_cnt] <= ^bus.s_data;
                        r_col_par            <= r_col_par ^ bus.s_data;
                        r_tot_par            <= r_tot_par ^ (^bus.s_data);
                        if (w_close) begin
                            r_state <= HOLD;
                            // Clean close only when s_last lands exactly on the final row.
                            r_frame_err <= (bus.s_last != w_at_last_row);
                        end else begin
                            r_row_cnt <= r_row_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (w_handoff) begin
                        r_state     <= FILL;
                        r_row_cnt   <= '0;
                        r_data      <= '0;
                        r_row_par   <= '0;
                        r_col_par   <= '0;
                        r_tot_par   <= 1'b0;
                        r_frame_cnt <= r_frame_cnt + 16'd1;
                    end
                end
                default: r_state <= FILL;
            endcase
        end
    end

    assign bus.data_out     = r_data;
    assign bus.row_parity   = r_row_par;
    assign bus.col_parity   = r_col_par;
    assign bus.total_parity = r_tot_par;
    assign bus.out_valid    = (r_state == HOLD);
    assign bus.frame_err    = r_frame_err;
    assign bus.frame_cnt    = r_frame_cnt;
endmodule

// File: tb/tb_fec_encoder.sv
// tb/tb_fec_encoder.sv - directed and seeded-random checks of fec_encoder frame, parity and handshake behaviour
module tb_fec_encoder;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic [15:0] exp_cnt = 16'd0;

    always #5 clk = ~clk;

    fec_encoder_if #(.WIDTH(4), .DEPTH(4)) bus ();

    fec_encoder #(.WIDTH(4), .DEPTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_row(input logic [3:0] d, input logic last);
        int t = 0;
        while (!bus.s_ready && t < 50) begin
            tick();
            t++;
        end
        if (!bus.s_ready) check("s_ready_timeout", 0, 1);
        bus.s_data  = d;
        bus.s_last  = last;
        bus.s_valid = 1'b1;
        tick();
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
    endtask

    // Holds out_ready for one edge while offering a row that must not be taken.
    task automatic handoff(input string tag);
        bus.out_ready = 1'b1;
        bus.s_valid   = 1'b1;
        bus.s_data    = 4'hF;
        bus.s_last    = 1'b1;
        tick();
        bus.out_ready = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_last    = 1'b0;
        exp_cnt++;
        check({tag, "_ovalid_off"}, bus.out_valid, 0);
        check({tag, "_sready_on"},  bus.s_ready, 1);
        check({tag, "_cnt"},        bus.frame_cnt, exp_cnt);
        check({tag, "_data_clr"},   bus.data_out, 0);
        check({tag, "_par_clr"},    {bus.row_parity, bus.col_parity, bus.total_parity}, 0);
    endtask

    task automatic check_frame(input string tag, input logic [15:0] d, input logic [3:0] rp,
                               input logic [3:0] cp, input logic tp, input logic err);
        check({tag, "_ovalid"}, bus.out_valid, 1);
        check({tag, "_sready"}, bus.s_ready, 0);
        check({tag, "_data"},   bus.data_out, d);
        check({tag, "_rp"},     bus.row_parity, rp);
        check({tag, "_cp"},     bus.col_parity, cp);
        check({tag, "_tp"},     bus.total_parity, tp);
        check({tag, "_ferr"},   bus.frame_err, err);
    endtask

    function automatic logic [15:0] decode(input logic [15:0] d, input logic [3:0] rp,
                                           input logic [3:0] cp, output logic err);
        logic [3:0] rs = rp;
        logic [3:0] cs = cp;
        logic [15:0] fixed = d;
        for (int i = 0; i < 4; i++) begin
            rs[i] ^= ^d[i*4 +: 4];
            cs    ^= d[i*4 +: 4];
        end
        err = (rs != 0) || (cs != 0);
        if ($countones(rs) == 1 && $countones(cs) == 1)
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    if (rs[i] && cs[j]) fixed[i*4 + j] = ~fixed[i*4 + j];
        return fixed;
    endfunction

    initial begin
        logic [3:0]  rows [4];
        logic [15:0] d;
        logic [3:0]  rp, cp;
        logic        tp, err;
        logic [15:0] flipped, fixed;
        logic [3:0]  hold_rp;

        bus.s_data = 4'h0; bus.s_valid = 1'b0; bus.s_last = 1'b0; bus.out_ready = 1'b0;
        tick();
        check("rst_sready_low", bus.s_ready, 0);
        tick();
        rst = 1'b0;
        #1;
        check("rst_state", {bus.out_valid, bus.frame_err, bus.frame_cnt, bus.data_out,
                            bus.row_parity, bus.col_parity, bus.total_parity}, 0);
        check("rst_sready_high", bus.s_ready, 1);

        // Odd row parity only on the last row; column 0 odd.
        send_row(4'hF, 0); send_row(4'hF, 0); send_row(4'hF, 0);
        check("v1_no_early_valid", bus.out_valid, 0);
        send_row(4'hE, 1);
        check_frame("v1", 16'hEFFF, 4'b1000, 4'b0001, 1'b1, 1'b0);
        handoff("v1_ho");

        // Back-pressure: outputs frozen while out_ready stays low.
        send_row(4'h1, 0); send_row(4'h2, 0); send_row(4'h4, 0); send_row(4'h8, 1);
        check_frame("v2", 16'h8421, 4'b1111, 4'b1111, 1'b0, 1'b0);
        hold_rp = bus.row_parity;
        for (int k = 0; k < 5; k++) begin
            tick();
            check("v2_hold", {bus.out_valid, bus.s_ready, bus.row_parity, bus.col_parity,
                              bus.total_parity, bus.data_out, bus.frame_err},
                  {1'b1, 1'b0, hold_rp, 4'b1111, 1'b0, 16'h8421, 1'b0});
        end
        handoff("v2_ho");

        // Early s_last: rows 2-3 zero, framing error pulse for one cycle.
        send_row(4'hA, 0); send_row(4'h6, 1);
        check_frame("v3", 16'h006A, 4'b0000, 4'b1100, 1'b0, 1'b1);
        tick();
        check("v3_ferr_pulse_end", bus.frame_err, 0);
        check("v3_still_valid", bus.out_valid, 1);
        handoff("v3_ho");

        // Missing s_last: frame still closes on row 3, error pulse.
        send_row(4'hF, 0); send_row(4'hF, 0); send_row(4'hF, 0); send_row(4'hF, 0);
        check_frame("v4", 16'hFFFF, 4'b0000, 4'b0000, 1'b0, 1'b1);
        tick();
        check("v4_ferr_pulse_end", bus.frame_err, 0);
        handoff("v4_ho");

        for (int f = 0; f < 4; f++) begin
            rp = 0; cp = 0; tp = 0;
            for (int i = 0; i < 4; i++) begin
                rows[i] = 4'($urandom_range(0, 15));
                d[i*4 +: 4] = rows[i];
                rp[i] = ^rows[i];
                cp ^= rows[i];
                tp ^= ^rows[i];
            end
            for (int i = 0; i < 4; i++) begin
                if (i == 2) tick();
                send_row(rows[i], i == 3);
            end
            check_frame("rnd", d, rp, cp, tp, 1'b0);
            fixed = decode(bus.data_out, bus.row_parity, bus.col_parity, err);
            check("rnd_dec_clean", {err, fixed}, {1'b0, d});
            flipped = bus.data_out;
            flipped[$urandom_range(0, 15)] ^= 1'b1;
            fixed = decode(flipped, bus.row_parity, bus.col_parity, err);
            check("rnd_dec_fix", {err, fixed}, {1'b1, d});
            handoff("rnd_ho");
        end

        // Reset mid-frame discards the partial frame and the frame count.
        send_row(4'h5, 0); send_row(4'h3, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_cnt = 16'd0;
        check("v5_rst_clear", {bus.out_valid, bus.frame_err, bus.frame_cnt, bus.data_out,
                               bus.row_parity, bus.col_parity, bus.total_parity}, 0);
        send_row(4'h7, 0); send_row(4'h1, 0); send_row(4'h8, 0); send_row(4'hC, 1);
        check_frame("v5", 16'hC817, 4'b0111, 4'b0010, 1'b1, 1'b0);
        handoff("v5_ho");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
